sm_accumulator: RTL
===================

# sm_accumulator

Sequential accumulator that sits directly downstream of the 9-bit sign-magnitude add/subtract ALU in the TPU datapath. It consumes a stream of 9-bit sign-magnitude operands over a valid/ready handshake and folds each operand into a running sum, adding or subtracting per beat. It presents the final sum, a beat count and a sticky overflow flag when the stream's last beat is accepted. Format is fixed: bit 8 is the sign (1 = negative) and bits 7:0 are the magnitude, identical to the ALU operands.

## Interface
- `WIDTH`, 9, total word width including the sign bit; only 9 is supported.
- `CNT_W`, 8, width of the accepted-beat counter.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream operand valid.
- `in_ready`  out  1  block can accept an operand.
- `in_data`  in  9  sign-magnitude operand.
- `in_sub`  in  1  0: acc + in_data; 1: acc − in_data. Same encoding as the ALU select.
- `in_last`  in  1  marks the final beat of the stream.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  9  accumulated sum, sign-magnitude.
- `out_count`  out  CNT_W  number of beats accepted in the stream.
- `out_ovf`  out  1  sticky: some beat in the stream overflowed the magnitude.

## Operation
- **States.** Two states: ACC and DONE. Reset enters ACC.
- **Reset values.** Accumulator = +0 (0x000), count = 0, ovf = 0, `out_valid` = 0, `in_ready` = 1, `out_data` = 0x000, `out_count` = 0, `out_ovf` = 0.
- **ACC state.**
  - `in_ready` = 1.
  - A beat is accepted when `in_valid && in_ready`.
  - On acceptance, the accumulator updates, the count increments, and ovf ORs in the beat's overflow.
  - If the accepted beat has `in_last` = 1, the state moves to DONE.
- **DONE state.**
  - `in_ready` = 0 and `out_valid` = 1.
  - `out_data`, `out_count` and `out_ovf` hold stable.
  - When `out_ready` = 1, the state returns to ACC and the accumulator, count and ovf clear in the same edge.
- **Effective operand.** Operand B = `in_data` with its sign inverted when `in_sub` = 1. An input of −0 (0x100) is treated as +0.
- **Same effective signs.** Result magnitude = |acc| + |B|, computed 9 bits wide; sign = the common sign. A carry out of bit 7 is an overflow.
- **Different signs.** Subtract the smaller magnitude from the larger; the sign is taken from the larger operand. Equal magnitudes give +0.
- **Zero normalisation.** The accumulator never holds −0; any zero result is stored as 0x000.
- **Count.** Saturates at 2^CNT_W − 1 and does not wrap.
- **Overflow handling.** Governed by the configuration macro.

## Timing
- **Latency.** `out_valid` rises on the cycle after the `in_last` beat is accepted; `out_data` already includes that beat.
- **Throughput.** One operand per cycle in ACC, with no bubbles between beats.
- **Result turnaround.** Minimum one cycle in DONE. With `out_ready` held high, `in_ready` returns the cycle after `out_valid` was first seen.
- **Backpressure.** `out_ready` low holds DONE indefinitely; outputs do not change.
- **Inputs in DONE.** `in_valid` asserted in DONE is ignored (not accepted); upstream must hold its beat.
- **Single-beat stream.** A stream consisting of one beat with `in_last` = 1 is legal; the result equals that operand (negated if `in_sub` = 1), with count = 1.
- **Mid-stream reset.** `rst` asserted during ACC or DONE discards the partial sum next edge; no result is emitted for the aborted stream.
- **Reset priority.** `rst` takes priority over all handshakes in the same cycle.

## Configuration
- Macro: `SM_ACC_SAT_EN`.
- **Defined.** On overflow the magnitude clamps to 255 with the sign of the true result (+255 = 0x0FF, −255 = 0x1FF); further same-direction beats stay clamped.
- **Undefined.** The magnitude wraps modulo 256 and keeps the result sign; a wrapped zero is normalised to +0.
- In both builds the ovf flag is set and sticky for the stream.

## Structure
- **Package `sm_pkg`:**
  - `typedef struct packed {logic sign; logic [7:0] mag;} sm9_t`
  - `SM_POS_ZERO` = 9'h000
  - `SM_MAG_MAX` = 8'd255
  - enum `sm_acc_state_e` {ACC, DONE}
- **Sub-module `sm_addsub_core`.** One combinational instance taking (a, b, sub) and returning (sum, ovf), including zero normalisation and the macro-dependent clamp/wrap.
- **Top level.** The top holds the state register, accumulator, counter and handshake logic.

## Test plan
- **Add, two positives.** Beats +3 (add), +2 (add, last) → `out_data` 0x005, `out_count` 2, `out_ovf` 0, `out_valid` one cycle after the last beat.
- **Mixed signs and subtract.**
  - +3 (add), then +2 with `in_sub` = 1 (last) → 0x001.
  - −3 (0x103) then +2 (last, add) → 0x101.
  - −3 then −2 with `in_sub` = 1 → 0x101.
- **Cancellation.** +3 (add), then −3 (0x103) add (last) → 0x000, never 0x100.
- **Overflow.** +200 (add), +100 (add, last) → with `SM_ACC_SAT_EN` 0x0FF and ovf = 1; without it 0x02C and ovf = 1. The next stream starts with ovf = 0.
- **Backpressure.**
  - Result ready, `out_ready` held low 3 cycles with `in_valid` = 1 → outputs stable, `in_ready` = 0, no beat accepted.
  - Raise `out_ready` → ACC next cycle with acc = 0x000 and count = 0.
- **Mid-stream reset.** Accept +5 and +7, assert `rst` for one cycle, then +1 (last) → 0x001, count = 1. All outputs read reset values during and after the reset cycle.

Source files
------------

// File: rtl/sm_accumulator_pkg.sv
// sm_pkg: shared types and constants for the 9-bit sign-magnitude accumulator.
// Word format: bit 8 = sign (1 = negative), bits 7:0 = magnitude.
package sm_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] mag;
  } sm9_t;

  localparam logic [8:0] SM_POS_ZERO = 9'h000;
  localparam logic [7:0] SM_MAG_MAX  = 8'd255;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    DONE = 1'b1
  } sm_acc_state_e;

endpackage : sm_pkg

// File: rtl/sm_accumulator_if.sv
// sm_accumulator_if: operand stream in, result stream out (valid/ready both ways).
// master = upstream/downstream environment, slave = accumulator.
interface sm_accumulator_if #(
  parameter int WIDTH = 9,
  parameter int CNT_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sub;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_sub, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_sub, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf
  );

endinterface : sm_accumulator_if

// File: rtl/sm_accumulator_addsub.sv
// sm_addsub_core: combinational sign-magnitude a +/- b with overflow detect.
// Zero results are always normalised to +0.
// Build option SM_ACC_SAT_EN: when defined, overflowing magnitudes clamp to 255;
// when undefined they wrap modulo 256. The overflow flag is raised in both cases.
module sm_addsub_core
  import sm_pkg::*;
(
  input  sm9_t a_i,
  input  sm9_t b_i,
  input  logic sub_i,
  output sm9_t sum_o,
  output logic ovf_o
);

  logic       a_sign_s;
  logic       b_sign_s;
  logic [8:0] sum9_s;
  logic       res_sign_s;
  logic [7:0] res_mag_s;
  logic       ovf_s;

  // Effective signs (-0 treated as +0), then magnitude add or subtract.
  always_comb begin
    a_sign_s   = (a_i.mag == 8'd0) ? 1'b0 : a_i.sign;
    b_sign_s   = (b_i.mag == 8'd0) ? 1'b0 : (b_i.sign ^ sub_i);
    sum9_s     = {1'b0, a_i.mag} + {1'b0, b_i.mag};
    res_sign_s = 1'b0;
    res_mag_s  = 8'd0;
    ovf_s      = 1'b0;
    if (a_sign_s == b_sign_s) begin
      res_sign_s = a_sign_s;
      ovf_s      = sum9_s[8];
      if (sum9_s[8]) begin
`ifdef SM_ACC_SAT_EN
        res_mag_s = SM_MAG_MAX;
`else
        res_mag_s = sum9_s[7:0];
`endif
      end else begin
        res_mag_s = sum9_s[7:0];
      end
    end else if (a_i.mag >= b_i.mag) begin
      res_sign_s = a_sign_s;
      res_mag_s  = a_i.mag - b_i.mag;
    end else begin
      res_sign_s = b_sign_s;
      res_mag_s  = b_i.mag - a_i.mag;
    end
  end

  // Drive outputs; any zero magnitude leaves as +0.
  always_comb begin
    sum_o.mag  = res_mag_s;
    sum_o.sign = (res_mag_s == 8'd0) ? 1'b0 : res_sign_s;
    ovf_o      = ovf_s;
  end

endmodule : sm_addsub_core

// File: rtl/sm_accumulator.sv
// sm_accumulator: folds a stream of 9-bit sign-magnitude operands into a running
// sum and presents sum, beat count and sticky overflow after the last beat.
// Build option SM_ACC_SAT_EN selects saturate (defined) vs wrap (undefined).
module sm_accumulator
  import sm_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  sm_accumulator_if.slave  bus
);

  localparam logic [0:0]       ST_ACC    = 1'(ACC);
  localparam logic [0:0]       ST_DONE   = 1'(DONE);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  logic [0:0]       state_q,     state_d;
  logic [WIDTH-1:0] acc_q,       acc_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic             ovf_q,       ovf_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;

  sm9_t core_sum_s;
  logic core_ovf_s;

  sm_addsub_core u_core (
    .a_i   (sm9_t'(acc_q)),
    .b_i   (sm9_t'(bus.in_data)),
    .sub_i (bus.in_sub),
    .sum_o (core_sum_s),
    .ovf_o (core_ovf_s)
  );

  // Next-state: accept beats in ACC, hold the result in DONE until taken.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_ACC: begin
        if (bus.in_valid && in_ready_q) begin
          acc_d   = WIDTH'(core_sum_s);
          count_d = (count_q == CNT_MAX) ? count_q : (count_q + CNT_ONE);
          ovf_d   = ovf_q | core_ovf_s;
          if (bus.in_last) begin
            state_d     = ST_DONE;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            state_d = ST_ACC;
          end
        end else begin
          state_d = ST_ACC;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d     = ST_ACC;
          acc_d       = SM_POS_ZERO;
          count_d     = CNT_ZERO;
          ovf_d       = 1'b0;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_ACC;
        acc_d       = SM_POS_ZERO;
        count_d     = CNT_ZERO;
        ovf_d       = 1'b0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACC;
      acc_q       <= SM_POS_ZERO;
      count_q     <= CNT_ZERO;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Outputs come straight from flops.
  always_comb begin
    bus.in_ready  = in_ready_q;
    bus.out_valid = out_valid_q;
    bus.out_data  = acc_q;
    bus.out_count = count_q;
    bus.out_ovf   = ovf_q;
  end

endmodule : sm_accumulator
